cpu7_ifu_ibuf: RTL and testbench

CPU7_IFU_IBUF -- requirements
Module: cpu7_ifu_ibuf

---
 rtl/cpu7_ifu_ibuf.sv | 129 ++++++++++++
 tb/tb_cpu7_ifu_ibuf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_ifu_ibuf.sv
// Instruction buffer between fetch and decode: circular queue of decoded-slot entries.
// Define CPU7_IBUF_BYPASS_EN to let an empty queue forward slot 0 to decode in the same cycle.
module cpu7_ifu_ibuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [1:0]       in_count,
  input  logic [127:0]     in_rdata,
  input  logic             in_ex,
  input  logic [5:0]       in_exccode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_ex,
  output logic [5:0]       out_exccode,
  output logic [PTR_W:0]   ibuf_cnt
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GRP_N = 4;

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic             ex_mem   [DEPTH];
  logic [5:0]       exc_mem  [DEPTH];

  logic [PTR_W-1:0] head_q, tail_q, head_d, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             empty_c;
  logic             accept_c;
  logic             deq_c;
  logic             skip_c;
  logic [2:0]       grp_n_c;
  logic [2:0]       wr_n_c;
  logic [31:0]      byp_pc_c;
  logic [31:0]      byp_inst_c;
  logic             byp_c;

  logic             wr_en   [GRP_N];
  logic [PTR_W-1:0] wr_idx  [GRP_N];
  logic [31:0]      wr_pc   [GRP_N];
  logic [31:0]      wr_inst [GRP_N];

  // Handshake, bypass selection and per-slot write decode
  always_comb begin
    empty_c    = (cnt_q == '0);
    in_ready   = !flush && ((CNT_W'(DEPTH) - cnt_q) >= CNT_W'(GRP_N));
    accept_c   = in_valid && in_ready;
    grp_n_c    = in_ex ? 3'd1 : (3'({1'b0, in_count}) + 3'd1);
    byp_pc_c   = in_pc;
    byp_inst_c = in_ex ? 32'd0 : in_rdata[31:0];
`ifdef CPU7_IBUF_BYPASS_EN
    byp_c      = empty_c && !flush && in_valid;
`else
    byp_c      = 1'b0;
`endif
    // A bypassed head that decode takes is never written into the queue
    skip_c     = byp_c && out_ready;
    wr_n_c     = grp_n_c - 3'(skip_c);
    deq_c      = !empty_c && out_ready && !flush;

    for (int i = 0; i < int'(GRP_N); i++) begin
      logic [1:0] slot;
      slot       = 2'(i) + 2'(skip_c);
      wr_en[i]   = accept_c && (3'(i) < wr_n_c);
      wr_idx[i]  = tail_q + PTR_W'(i);
      wr_pc[i]   = in_ex ? in_pc : (in_pc + {28'd0, slot, 2'b00});
      wr_inst[i] = in_ex ? 32'd0 : in_rdata[{slot, 5'd0} +: 32];
    end

    head_d = head_q + PTR_W'(deq_c);
    tail_d = tail_q + (accept_c ? PTR_W'(wr_n_c) : PTR_W'(0));
    cnt_d  = cnt_q + (accept_c ? CNT_W'(wr_n_c) : CNT_W'(0)) - CNT_W'(deq_c);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  // Head presentation toward decode
  always_comb begin
    out_valid   = !empty_c || byp_c;
    out_pc      = pc_mem[head_q];
    out_inst    = inst_mem[head_q];
    out_ex      = ex_mem[head_q];
    out_exccode = exc_mem[head_q];
    if (byp_c) begin
      out_pc      = byp_pc_c;
      out_inst    = byp_inst_c;
      out_ex      = in_ex;
      out_exccode = in_exccode;
    end
    ibuf_cnt = cnt_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry payload needs no reset; validity is carried by cnt_q
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(GRP_N); i++) begin
      if (wr_en[i]) begin
        pc_mem[wr_idx[i]]   <= wr_pc[i];
        inst_mem[wr_idx[i]] <= wr_inst[i];
        ex_mem[wr_idx[i]]   <= in_ex;
        exc_mem[wr_idx[i]]  <= in_exccode;
      end
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Scoreboard bench for cpu7_ifu_ibuf: stimulus pushes expected entries, a negedge monitor pops them.
module tb_cpu7_ifu_ibuf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [5:0]  code;
  } ent_t;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_pc = '0;
  logic [1:0]   in_count = '0;
  logic [127:0] in_rdata = '0;
  logic         in_ex = 1'b0;
  logic [5:0]   in_exccode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_pc;
  logic [31:0]  out_inst;
  logic         out_ex;
  logic [5:0]   out_exccode;
  logic [3:0]   ibuf_cnt;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];
  bit   rnd_done;

  cpu7_ifu_ibuf #(.DEPTH(8), .PTR_W(3)) dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_count(in_count),
    .in_rdata(in_rdata), .in_ex(in_ex), .in_exccode(in_exccode),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_ex(out_ex), .out_exccode(out_exccode), .ibuf_cnt(ibuf_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present one group, wait (bounded) for in_ready, record expected entries, hold for the accept edge
  task automatic send_group(input logic [31:0] pc, input logic [1:0] cnt, input logic ex,
                            input logic [5:0] code, input logic [127:0] data);
    int   w;
    ent_t e;
    logic [127:0] d;
    w = 0;
    d = data;
    in_valid = 1'b1; in_pc = pc; in_count = cnt; in_ex = ex; in_exccode = code; in_rdata = data;
    while (!in_ready && w < 200) begin
      cyc();
      w++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (ex) begin
      e = '{pc: pc, inst: 32'd0, ex: 1'b1, code: code};
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i <= int'(cnt); i++) begin
        e = '{pc: pc + 32'(4 * i), inst: d[32*i +: 32], ex: 1'b0, code: code};
        exp_q.push_back(e);
      end
    end
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    out_ready = 1'b1;
    while (out_valid && w < 100) begin
      cyc();
      w++;
    end
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_queue_left", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
  endtask

  // Monitor: every handshake at decode must match the next expected entry
  always @(negedge clock) begin
    if (resetn && !flush && out_valid && out_ready) begin
      ent_t got, e;
      got = '{pc: out_pc, inst: out_inst, ex: out_ex, code: out_exccode};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual pc=%h required none", out_pc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out_entry actual pc=%h inst=%h ex=%b code=%h required pc=%h inst=%h ex=%b code=%h",
                   got.pc, got.inst, got.ex, got.code, e.pc, e.inst, e.ex, e.code);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(ibuf_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    cyc();

    // One four-wide group streamed straight out
    out_ready = 1'b1;
    send_group(32'h1c00_0000, 2'd3, 1'b0, 6'd0,
               128'h4444_4444_3333_3333_2222_2222_1111_1111);
`ifndef CPU7_IBUF_BYPASS_EN
    for (int k = 0; k < 4; k++) begin
      chk("g35_valid", 32'(out_valid), 32'd1);
      chk("g35_pc", out_pc, 32'h1c00_0000 + 32'(4 * k));
      cyc();
    end
    chk("g35_empty", 32'(out_valid), 32'd0);
`endif
    drain();

    // Fill to DEPTH, then drain through the in_ready threshold
    out_ready = 1'b0;
    send_group(32'h0000_0100, 2'd3, 1'b0, 6'd0, 128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0);
    send_group(32'h0000_0200, 2'd3, 1'b0, 6'd0, 128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0);
    chk("full_cnt", 32'(ibuf_cnt), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("deq1_cnt", 32'(ibuf_cnt), 32'd7);
    chk("deq1_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    out_ready = 1'b0;
    chk("deq4_cnt", 32'(ibuf_cnt), 32'd4);
    chk("deq4_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Flush with a group presented in the same cycle
    send_group(32'h0000_0300, 2'd3, 1'b0, 6'd0, 128'h1);
    send_group(32'h0000_0400, 2'd1, 1'b0, 6'd0, 128'h2);
    chk("pre_flush_cnt", 32'(ibuf_cnt), 32'd6);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h0000_0500; in_count = 2'd3; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("post_flush_cnt", 32'(ibuf_cnt), 32'd0);
    chk("post_flush_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("flush_group_dropped", 32'(ibuf_cnt), 32'd0);

    // Exception group collapses to one entry
    send_group(32'h0000_0600, 2'd3, 1'b1, 6'h08, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("ex_cnt", 32'(ibuf_cnt), 32'd1);
    chk("ex_flag", 32'(out_ex), 32'd1);
    chk("ex_code", 32'(out_exccode), 32'h08);
    chk("ex_inst", out_inst, 32'd0);
    chk("ex_pc", out_pc, 32'h0000_0600);
    drain();

    // Reset mid-operation discards contents
    send_group(32'h0000_0700, 2'd2, 1'b0, 6'd0, 128'h3);
    resetn = 1'b0;
    #2;
    exp_q.delete();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(ibuf_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    cyc();
    send_group(32'h0000_0800, 2'd0, 1'b0, 6'd0, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D);
`ifndef CPU7_IBUF_BYPASS_EN
    chk("midrst_lat_valid", 32'(out_valid), 32'd1);
    chk("midrst_lat_inst", out_inst, 32'hCAFE_F00D);
`endif
    drain();

`ifdef CPU7_IBUF_BYPASS_EN
    // Empty-queue bypass: same-cycle delivery, nothing enqueued
    begin
      ent_t e;
      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = 32'h0000_0900; in_count = 2'd0; in_ex = 1'b0;
      in_rdata = 128'h0000_0000_0000_0000_0000_0000_1234_5678;
      e = '{pc: 32'h0000_0900, inst: 32'h1234_5678, ex: 1'b0, code: 6'd0};
      exp_q.push_back(e);
      #1;
      chk("byp_same_cycle_valid", 32'(out_valid), 32'd1);
      cyc();
      in_valid = 1'b0;
      chk("byp_cnt", 32'(ibuf_cnt), 32'd0);
      drain();
    end
`endif

    // 100 groups with random decode back-pressure, including a PC wrap
    rnd_done = 1'b0;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int g = 0; g < 100; g++) begin
          logic [31:0] pc;
          pc = (g == 50) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
          repeat ($urandom_range(0, 2)) cyc();
          send_group(pc, 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                     6'($urandom_range(0, 63)), {$urandom, $urandom, $urandom, $urandom});
        end
        rnd_done = 1'b1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
